// File: rtl/fir_tap_arbiter.sv
// fir_tap_arbiter: shares the single-port tap-coefficient BRAM between the AXI-Lite host and the FIR engine
// Ports:
//   axis_clk, axis_rst_n            clock, asynchronous active-low reset
//   h_req/h_we/h_addr/h_wdata       host request by byte address (h_we=0 is a read)
//   h_gnt/h_rvalid/h_rdata/h_err    host grant, read return, out-of-window error
//   e_req/e_idx/e_lock              engine read request by tap index, burst lock
//   e_gnt/e_rvalid/e_rdata          engine grant and read return
//   tap_EN/tap_WE/tap_A/tap_Di      BRAM command, driven combinationally from the winner
//   tap_Do                          BRAM read data, one cycle after the address
// Optional: define FIR_TAP_ARB_STARVE_GUARD_EN to force a host grant after MAX_WAIT blocked cycles.
module fir_tap_arbiter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int TAP_BASE    = 'h20,
  parameter int MAX_WAIT    = 8
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   h_req,
  input  logic [3:0]             h_we,
  input  logic [pADDR_WIDTH-1:0] h_addr,
  input  logic [pDATA_WIDTH-1:0] h_wdata,
  output logic                   h_gnt,
  output logic                   h_rvalid,
  output logic [pDATA_WIDTH-1:0] h_rdata,
  output logic                   h_err,
  input  logic                   e_req,
  input  logic [3:0]             e_idx,
  input  logic                   e_lock,
  output logic                   e_gnt,
  output logic                   e_rvalid,
  output logic [pDATA_WIDTH-1:0] e_rdata,
  output logic                   tap_EN,
  output logic [3:0]             tap_WE,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);
  localparam logic [0:0] NONE          = 1'b0;
  localparam logic [0:0] ENGINE_LOCKED = 1'b1;
  localparam logic [pADDR_WIDTH-1:0] WIN_LO = pADDR_WIDTH'(TAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] WIN_HI = pADDR_WIDTH'(TAP_BASE + 4 * (Tape_Num - 1));
  logic [0:0] owner;
  logic       rd_pend_h, rd_pend_e;
  logic [1:0] err_pend;
  logic       hr, er, h_force, e_win, h_win, e_oor, h_oor, h_rd, e_bram, h_bram;
  // requests are masked in reset so every output, combinational ones included, reads 0
  assign hr = h_req & axis_rst_n;
  assign er = e_req & axis_rst_n;
`ifdef FIR_TAP_ARB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;
  assign h_force = hr && wait_cnt == WW'(MAX_WAIT);
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) wait_cnt <= '0;
    else wait_cnt <= (!hr || h_gnt) ? '0 : h_force ? wait_cnt : wait_cnt + 1'b1;
`else
  // no guard: MAX_WAIT < 0 never holds, so the host is never forced
  assign h_force = hr && (MAX_WAIT < 0);
`endif
  assign e_oor  = 32'(e_idx) >= Tape_Num;
  assign h_oor  = h_addr < WIN_LO || h_addr > WIN_HI || h_addr[1:0] != 2'b00;
  assign h_rd   = h_we == 4'h0;
  // a forced host grant steals one cycle from the engine without dropping its lock
  assign e_win  = er && !h_force;
  assign h_win  = hr && !e_win && (owner == NONE || h_force);
  assign e_bram = e_win && !e_oor;
  assign h_bram = h_win && !h_oor;
  assign e_gnt  = e_win;
  assign h_gnt  = h_win;
  assign tap_EN = e_bram || h_bram;
  assign tap_WE = h_bram ? h_we : 4'h0;
  assign tap_A  = e_bram ? pADDR_WIDTH'({e_idx, 2'b00}) : h_bram ? h_addr - WIN_LO : '0;
  assign tap_Di = h_bram ? h_wdata : '0;
  assign h_rvalid = rd_pend_h;
  assign e_rvalid = rd_pend_e;
  assign h_rdata  = rd_pend_h && !err_pend[0] ? tap_Do : '0;
  assign e_rdata  = rd_pend_e && !err_pend[1] ? tap_Do : '0;
  assign h_err    = (h_win && !h_rd && h_oor) || (rd_pend_h && err_pend[0]);
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      owner     <= NONE;
      rd_pend_h <= 1'b0;
      rd_pend_e <= 1'b0;
      err_pend  <= 2'b00;
    end else begin
      owner     <= owner == NONE ? (e_win && e_lock ? ENGINE_LOCKED : NONE)
                                 : (er && e_lock ? ENGINE_LOCKED : NONE);
      rd_pend_e <= e_win;
      rd_pend_h <= h_win && h_rd;
      err_pend  <= {e_win && e_oor, h_win && h_rd && h_oor};
    end
endmodule

// File: tb/tb_fir_tap_arbiter.sv
// tb_fir_tap_arbiter: table-driven and sequence checks of fir_tap_arbiter with a read-return scoreboard
module tb_fir_tap_arbiter;
`ifdef FIR_TAP_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic        axis_clk = 1'b0, axis_rst_n = 1'b0;
  logic        h_req = 0, e_req = 0, e_lock = 0;
  logic [3:0]  h_we = 0, e_idx = 0;
  logic [11:0] h_addr = 0;
  logic [31:0] h_wdata = 0;
  logic        h_gnt, h_rvalid, h_err, e_gnt, e_rvalid, tap_EN;
  logic [31:0] h_rdata, e_rdata, tap_Di;
  logic [3:0]  tap_WE;
  logic [11:0] tap_A;
  logic [31:0] tap_Do = '0;
  logic [31:0] mem [16] = '{default: '0};
  logic [31:0] ref_mem [16] = '{default: '0};
  int cyc = 0, n_pass = 0, n_tot = 0;
  typedef struct { logic [31:0] data; logic err; int due; } rd_t;
  rd_t h_sb[$], e_sb[$];
  typedef struct {
    logic hreq; logic [3:0] hwe; logic [11:0] haddr; logic [31:0] hd; logic ereq; logic [3:0] eidx;
    logic hg; logic eg; logic en; logic [3:0] we; logic [11:0] a; logic [31:0] di; logic herr;
  } vec_t;
  vec_t vecs[18];

  fir_tap_arbiter dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
    .e_req(e_req), .e_idx(e_idx), .e_lock(e_lock),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do)
  );

  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;

  always @(posedge axis_clk)
    if (tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) mem[tap_A[5:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= mem[tap_A[5:2]];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge axis_clk) begin
    rd_t r;
    if (h_rvalid) begin
      if (h_sb.size() == 0) chk("h_rvalid_unexpected", 1, 0);
      else begin
        r = h_sb.pop_front();
        chk("h_rdata", h_rdata, r.data);
        chk("h_err_ret", 32'(h_err), 32'(r.err));
        chk("h_ret_cycle", cyc, r.due);
      end
    end
    if (e_rvalid) begin
      if (e_sb.size() == 0) chk("e_rvalid_unexpected", 1, 0);
      else begin
        r = e_sb.pop_front();
        chk("e_rdata", e_rdata, r.data);
        chk("e_ret_cycle", cyc, r.due);
      end
    end
  end

  task automatic drive(input logic hq, input logic [3:0] hwe, input logic [11:0] ha, input logic [31:0] hd,
                       input logic eq, input logic [3:0] ei, input logic el);
    h_req = hq; h_we = hwe; h_addr = ha; h_wdata = hd; e_req = eq; e_idx = ei; e_lock = el;
  endtask

  task automatic next_cycle();
    @(posedge axis_clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int idx;
    logic hpend, forced;
    vecs[0]  = '{1, 4'hF, 12'h024, 32'hA5A5_0001, 0, 0,  1, 0, 1, 4'hF, 12'h004, 32'hA5A5_0001, 0};
    vecs[1]  = '{1, 4'h0, 12'h024, 32'h0,         0, 0,  1, 0, 1, 4'h0, 12'h004, 32'h0, 0};
    vecs[2]  = '{1, 4'h3, 12'h048, 32'h1234_5678, 0, 0,  1, 0, 1, 4'h3, 12'h028, 32'h1234_5678, 0};
    vecs[3]  = '{1, 4'h0, 12'h048, 32'h0,         0, 0,  1, 0, 1, 4'h0, 12'h028, 32'h0, 0};
    vecs[4]  = '{1, 4'hF, 12'h02C, 32'hDEAD_BEEF, 0, 0,  1, 0, 1, 4'hF, 12'h00C, 32'hDEAD_BEEF, 0};
    vecs[5]  = '{1, 4'hF, 12'h030, 32'h0BAD_F00D, 0, 0,  1, 0, 1, 4'hF, 12'h010, 32'h0BAD_F00D, 0};
    vecs[6]  = '{1, 4'h0, 12'h030, 32'h0,         1, 3,  0, 1, 1, 4'h0, 12'h00C, 32'h0, 0};
    vecs[7]  = '{1, 4'h0, 12'h030, 32'h0,         0, 0,  1, 0, 1, 4'h0, 12'h010, 32'h0, 0};
    vecs[8]  = '{1, 4'h0, 12'h04C, 32'h0,         0, 0,  1, 0, 0, 4'h0, 12'h000, 32'h0, 0};
    vecs[9]  = '{0, 4'h0, 12'h000, 32'h0,         1, 11, 0, 1, 0, 4'h0, 12'h000, 32'h0, 0};
    vecs[10] = '{1, 4'hF, 12'h04C, 32'hFFFF_FFFF, 0, 0,  1, 0, 0, 4'h0, 12'h000, 32'h0, 1};
    vecs[11] = '{1, 4'h0, 12'h022, 32'h0,         0, 0,  1, 0, 0, 4'h0, 12'h000, 32'h0, 0};
    vecs[12] = '{1, 4'h0, 12'h01C, 32'h0,         0, 0,  1, 0, 0, 4'h0, 12'h000, 32'h0, 0};
    vecs[13] = '{0, 4'h0, 12'h000, 32'h0,         1, 10, 0, 1, 1, 4'h0, 12'h028, 32'h0, 0};
    vecs[14] = '{0, 4'h0, 12'h000, 32'h0,         0, 0,  0, 0, 0, 4'h0, 12'h000, 32'h0, 0};
    vecs[15] = '{1, 4'h0, 12'h020, 32'h0,         0, 0,  1, 0, 1, 4'h0, 12'h000, 32'h0, 0};
    vecs[16] = '{1, 4'h0, 12'h024, 32'h0,         1, 1,  0, 1, 1, 4'h0, 12'h004, 32'h0, 0};
    vecs[17] = '{1, 4'h0, 12'h024, 32'h0,         0, 0,  1, 0, 1, 4'h0, 12'h004, 32'h0, 0};

    drive(1, 4'hF, 12'h024, 32'hFFFF_FFFF, 1, 2, 1);
    @(negedge axis_clk);
    chk("rst_h_gnt", 32'(h_gnt), 0);
    chk("rst_e_gnt", 32'(e_gnt), 0);
    chk("rst_tap_EN", 32'(tap_EN), 0);
    chk("rst_tap_A", 32'(tap_A), 0);
    chk("rst_tap_Di", tap_Di, 0);
    chk("rst_tap_WE", 32'(tap_WE), 0);
    next_cycle();
    axis_rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      next_cycle();
      drive(vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hd, vecs[i].ereq, vecs[i].eidx, 1'b0);
      @(negedge axis_clk);
      chk($sformatf("v%0d_h_gnt", i), 32'(h_gnt), 32'(vecs[i].hg));
      chk($sformatf("v%0d_e_gnt", i), 32'(e_gnt), 32'(vecs[i].eg));
      chk($sformatf("v%0d_tap_EN", i), 32'(tap_EN), 32'(vecs[i].en));
      chk($sformatf("v%0d_tap_WE", i), 32'(tap_WE), 32'(vecs[i].we));
      chk($sformatf("v%0d_tap_A", i), 32'(tap_A), 32'(vecs[i].a));
      chk($sformatf("v%0d_tap_Di", i), tap_Di, vecs[i].di);
      if (vecs[i].hwe != 0) chk($sformatf("v%0d_h_err", i), 32'(h_err), 32'(vecs[i].herr));
      if (vecs[i].hg && vecs[i].hwe == 0)
        h_sb.push_back('{vecs[i].en ? ref_mem[vecs[i].a[5:2]] : 32'h0, !vecs[i].en, cyc + 1});
      if (vecs[i].eg)
        e_sb.push_back('{vecs[i].en ? ref_mem[vecs[i].a[5:2]] : 32'h0, 1'b0, cyc + 1});
      if (vecs[i].hg && vecs[i].en && vecs[i].hwe != 0)
        for (int b = 0; b < 4; b++)
          if (vecs[i].hwe[b]) ref_mem[vecs[i].a[5:2]][8*b +: 8] = vecs[i].hd[8*b +: 8];
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);

    // locked engine burst over idx 0..10 while the host waits on a read of 'h20
    next_cycle();
    idx = 0;
    hpend = 1'b1;
    for (int c = 0; c < (GUARD ? 12 : 11); c++) begin
      forced = GUARD && c == 8;
      drive(hpend, 0, 12'h020, 0, 1, 4'(idx), 1);
      @(negedge axis_clk);
      chk($sformatf("lock%0d_e_gnt", c), 32'(e_gnt), 32'(!forced));
      chk($sformatf("lock%0d_h_gnt", c), 32'(h_gnt), 32'(forced));
      chk($sformatf("lock%0d_tap_A", c), 32'(tap_A), forced ? 32'h0 : 32'(idx * 4));
      if (forced) begin
        h_sb.push_back('{ref_mem[0], 1'b0, cyc + 1});
        hpend = 1'b0;
      end else begin
        e_sb.push_back('{ref_mem[idx], 1'b0, cyc + 1});
        idx++;
      end
      next_cycle();
    end
    drive(hpend, 0, 12'h020, 0, 0, 0, 0);
    if (hpend) begin
      @(negedge axis_clk);
      chk("release_h_gnt_blocked", 32'(h_gnt), 0);
      next_cycle();
      @(negedge axis_clk);
      chk("release_h_gnt", 32'(h_gnt), 1);
      chk("release_tap_A", 32'(tap_A), 0);
      h_sb.push_back('{ref_mem[0], 1'b0, cyc + 1});
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) next_cycle();

    // reset asserted right after a locked engine read grant
    drive(0, 0, 0, 0, 1, 2, 1);
    @(negedge axis_clk);
    chk("mid_e_gnt", 32'(e_gnt), 1);
    axis_rst_n = 1'b0;
    next_cycle();
    @(negedge axis_clk);
    chk("mid_rst_e_rvalid", 32'(e_rvalid), 0);
    chk("mid_rst_e_gnt", 32'(e_gnt), 0);
    chk("mid_rst_tap_EN", 32'(tap_EN), 0);
    chk("mid_rst_tap_A", 32'(tap_A), 0);
    next_cycle();
    axis_rst_n = 1'b1;
    drive(1, 0, 12'h024, 0, 0, 0, 0);
    @(negedge axis_clk);
    chk("post_rst_owner_none", 32'(h_gnt), 1);
    h_sb.push_back('{ref_mem[1], 1'b0, cyc + 1});
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();
    chk("h_sb_drained", h_sb.size(), 0);
    chk("e_sb_drained", e_sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/fir_tap_arbiter.md
Name: fir_tap_arbiter

Overview:
Arbitrates the single-port tap-coefficient BRAM between two requesters. The host requester is the AXI-Lite configuration path, which reads and writes coefficients by byte address. The engine requester is the FIR MAC sequencer, which reads coefficients by tap index. The block sits between both requesters and the tap BRAM, translates addresses and tracks read-return latency. It supports engine burst locking, with an optional host starvation guard.

Parameters:
pADDR_WIDTH, 12, BRAM/AXI-Lite address width
pDATA_WIDTH, 32, data width
Tape_Num, 11, number of taps; engine index range 0..Tape_Num-1
TAP_BASE, 'h20, host byte address of tap 0
MAX_WAIT, 8, host wait cycles before forced grant (optional feature only)

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  asynchronous active-low reset
h_req  in  1  host access request, held until h_gnt
h_we  in  4  host byte write enables; 0 = read
h_addr  in  pADDR_WIDTH  host byte address
h_wdata  in  pDATA_WIDTH  host write data
h_gnt  out  1  host access issued this cycle
h_rvalid  out  1  host read data valid
h_rdata  out  pDATA_WIDTH  host read data
h_err  out  1  host address out of window (with h_rvalid or write grant)
e_req  in  1  engine read request
e_idx  in  4  engine tap index
e_lock  in  1  engine holds ownership across consecutive requests
e_gnt  out  1  engine access issued this cycle
e_rvalid  out  1  engine read data valid
e_rdata  out  pDATA_WIDTH  engine read data
tap_EN  out  1  BRAM enable
tap_WE  out  4  BRAM byte write enables
tap_A  out  pADDR_WIDTH  BRAM byte address
tap_Di  out  pDATA_WIDTH  BRAM write data
tap_Do  in  pDATA_WIDTH  BRAM read data, one cycle after address

Behaviour:
- Reset is asynchronous and active-low on axis_rst_n; the block runs on axis_clk.
- Reset state: all registered state cleared (owner=NONE, wait_cnt=0, rd_pend_h=rd_pend_e=0, err_pend=0).
- While in reset, all outputs are 0.
- Decision is combinational in the cycle of request; BRAM signals are driven combinationally from the winner in the same cycle.
- Owner states: NONE, ENGINE_LOCKED.
  - NONE -> ENGINE_LOCKED when e_gnt and e_lock are both 1.
  - ENGINE_LOCKED -> NONE in the first cycle where e_lock=0 or e_req=0.
- Priority:
  - In ENGINE_LOCKED, only the engine may be granted.
  - In NONE, engine beats host when both request (fixed priority).
  - The loser keeps its request; gnt is only asserted for the winner.
- Engine access: tap_EN=1, tap_WE=0, tap_A=e_idx<<2.
  - e_idx >= Tape_Num: granted, tap_EN=0; e_rvalid next cycle with e_rdata=0.
- Host access:
  - Window is TAP_BASE <= h_addr <= TAP_BASE+4*(Tape_Num-1), word aligned.
  - In window: tap_EN=1, tap_WE=h_we, tap_A=h_addr-TAP_BASE, tap_Di=h_wdata.
  - Out of window: h_gnt=1, tap_EN=0.
    - Read: h_rvalid next cycle with h_rdata=0 and h_err=1.
    - Write: h_err=1 in the grant cycle and nothing is written.
- Read return:
  - A granted read (WE=0) sets rd_pend_x for exactly one cycle.
  - Next cycle: x_rvalid=1 and x_rdata=tap_Do (or 0 on error).
  - rdata is 0 whenever rvalid=0.
- Back-to-back: either requester may be granted on consecutive cycles; throughput is 1 access/cycle.
  - Engine read at cycle N and host read at N+1 return on N+1 and N+2 to their own ports respectively.
- Writes produce no rvalid.
- Idle: tap_EN=0, tap_WE=0, tap_A=0, tap_Di=0.
- Reset mid-operation: pending returns are discarded; no rvalid after reset release until a new grant.

Optional Feature:
Macro FIR_TAP_ARB_STARVE_GUARD_EN.
- Defined:
  - wait_cnt increments each cycle h_req=1 and h_gnt=0, saturating at MAX_WAIT, and clears on h_gnt or h_req=0.
  - When wait_cnt==MAX_WAIT, host wins the next arbitration even in ENGINE_LOCKED.
  - Engine lock is preserved: the owner state stays ENGINE_LOCKED and e_gnt=0 for that cycle only.
- Undefined: no counter; an engine lock can starve the host indefinitely.

Test Plan:
- Host writes 'h24 data 'hA5A5_0001 with h_we=4'hF -> h_gnt same cycle, tap_A='h04, tap_WE=4'hF, tap_Di='hA5A5_0001. A host read of 'h24 then returns h_rvalid one cycle later with h_rdata='hA5A5_0001.
- Engine reads idx 0..10 back-to-back with e_lock=1 while host requests read 'h20 -> 11 e_gnt in consecutive cycles with tap_A=0,4,...,40. h_gnt comes in the cycle after lock release; e_rvalid pulses 11 consecutive cycles.
- Simultaneous e_req (idx 3) and h_req (read 'h30), no lock -> e_gnt first with tap_A='h0C, then h_gnt next cycle with tap_A='h10. Returns arrive on e_rvalid, then h_rvalid, in consecutive cycles.
- Host read 'h4C (out of window) -> h_gnt, tap_EN=0, next cycle h_rvalid=1, h_err=1, h_rdata=0. Engine idx 11 -> e_rvalid with e_rdata=0.
- With FIR_TAP_ARB_STARVE_GUARD_EN, MAX_WAIT=8, engine locked continuously -> host granted after exactly 8 wait cycles. The engine is denied that one cycle and resumes the next. Without the macro, the host is never granted during the lock.
- Assert axis_rst_n low the cycle after an engine read grant -> e_rvalid stays 0, all tap_* outputs are 0 during reset, and owner is NONE after release.
